imem_lat_responder: RTL

Responder for the tagged instruction-memory fetch protocol (address + tag + valid in, data + tag + valid out). It models a slower backing store behind the fetch unit with a programmable fixed latency and a bounded in-flight queue. It adds a ready signal so the fetch unit can be stalled. It drops in where the single-cycle instruction memory sits, for latency-tolerance work on the fetch path.

---
 rtl/imem_lat_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imem_lat_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_lat_responder
// Description : Tagged instruction-memory responder with a programmable fixed
//               latency and a bounded in-order in-flight queue. It exposes a
//               ready signal so the fetch unit can be stalled, and it honours
//               a flush that discards every outstanding request.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_lat_responder #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 32,
  parameter int    TAG_WIDTH  = 4,
  parameter int    LATENCY    = 3,
  parameter int    QDEPTH     = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [TAG_WIDTH-1:0]  rtag_in,
  input  logic                  rvalid_in,
  output logic                  rready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [TAG_WIDTH-1:0]  rtag_out,
  output logic                  rvalid_out
);

  // Geometry of the backing store and the in-flight queue.
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IDX_W;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  // The countdown never holds more than LATENCY-1.
  localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(QDEPTH - 1);
  localparam logic [CD_W-1:0]  LOAD_CD    = CD_W'(LATENCY - 1);

  // Backing store; contents survive reset.
  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Queue payload: word index, tag and remaining countdown per slot.
  logic [IDX_W-1:0]     q_idx [QDEPTH];
  logic [TAG_WIDTH-1:0] q_tag [QDEPTH];
  logic [CD_W-1:0]      q_cd  [QDEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic [IDX_W-1:0] word_idx;
  logic             unused_low_bits;

  // Advance a queue pointer with wrap at QDEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The byte offset inside a word is irrelevant to a word-wide fetch.
  assign word_idx        = raddr[ADDR_WIDTH-1:2];
  assign unused_low_bits = ^raddr[1:0];

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a request in that cycle; it is forced low in reset.
  assign rready = (count < FULL_COUNT) && rst_n;

  // Accepted requests are those that meet ready without a flush; a flush
  // also suppresses the head pop that would otherwise fall on that edge.
  assign push = rvalid_in && rready && !flush;
  assign pop  = (count != '0) && (q_cd[head] == '0) && !flush;

  // Queue pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot payload: a push loads its slot, every other live countdown ticks down.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (push && (tail == PTR_W'(i))) begin
        q_idx[i] <= word_idx;
        q_tag[i] <= rtag_in;
        q_cd[i]  <= LOAD_CD;
      end else if (q_cd[i] != '0) begin
        q_cd[i] <= q_cd[i] - 1'b1;
      end
    end
  end

  // Synchronous read on the pop edge; data and tag hold between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_out <= 1'b0;
      rdata      <= '0;
      rtag_out   <= '0;
    end else if (flush) begin
      rvalid_out <= 1'b0;
    end else begin
      rvalid_out <= pop;
      if (pop) begin
        rdata    <= mem[q_idx[head]];
        rtag_out <= q_tag[head];
      end
    end
  end

endmodule
`default_nettype wire
